// File: rtl/matrix_pkg.sv
// Shared types and constants for the HUB75 colour pipeline: defaults,
// the 8-entry band palette and the row-builder state encoding.
package matrix_pkg;

  localparam int COLS_DEF  = 32;
  localparam int ROW_W_DEF = 5;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb3_t;

  // Entries 0..3 colour the upper half, 4..7 the lower half, same band index.
  localparam rgb3_t PALETTE [8] = '{
    3'b100, 3'b001, 3'b010, 3'b110,
    3'b110, 3'b101, 3'b011, 3'b111
  };

  typedef enum logic [1:0] {IDLE, BUILD, COMMIT} state_t;

endpackage

// File: rtl/band_color_lut.sv
// Combinational colour lookup: physical column (and row, for diagonal
// bands) to the upper/lower half colours of that pixel.
module band_color_lut
  import matrix_pkg::*;
#(
  parameter int COLS   = COLS_DEF,
  parameter int COL_W  = 5,
  parameter int ROW_W  = ROW_W_DEF,
  parameter int BAND_W = 10,
  parameter int DIAG   = 0
) (
  input  logic [COL_W-1:0] pc,
  input  logic [ROW_W-1:0] row,
  output rgb3_t            upper,
  output rgb3_t            lower
);

  logic [1:0] band;

  // Only the low two bits of the band count matter: four bands repeat.
  always_comb begin
    band  = 2'(32'(pc) / 32'(BAND_W) + ((DIAG != 0) ? 32'(row) : 32'd0));
    upper = PALETTE[{1'b0, band}];
    lower = PALETTE[{1'b1, band}];
  end

endmodule

// File: rtl/scroll_pattern_gen.sv
// Row builder for the HUB75 scan FSM: serially builds six colour planes for
// a requested row into a shadow buffer, then commits them to the outputs.
module scroll_pattern_gen
  import matrix_pkg::*;
#(
  parameter int COLS       = COLS_DEF,
  parameter int ROW_W      = ROW_W_DEF,
  parameter int BAND_W     = 10,
  parameter int SCROLL_DIV = 2,
  parameter int DIAG       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             row_req,
  input  logic [ROW_W-1:0] row_addr,
  input  logic             frame_tick,
  input  logic             pause,
  output logic             row_ready,
  output logic             row_valid,
  output logic [ROW_W-1:0] row_addr_out,
  output logic [COLS-1:0]  r1,
  output logic [COLS-1:0]  g1,
  output logic [COLS-1:0]  b1,
  output logic [COLS-1:0]  r2,
  output logic [COLS-1:0]  g2,
  output logic [COLS-1:0]  b2,
  output logic             req_drop
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  state_t           state_reg, state_next;
  logic [COL_W-1:0] col_reg;
  logic [COL_W-1:0] snap_reg;
  logic [COL_W-1:0] offset_reg;
  logic [DIV_W-1:0] div_reg;
  logic [ROW_W-1:0] row_reg;
  logic [ROW_W-1:0] row_addr_out_reg;
  logic             row_valid_reg;
  logic             req_drop_reg;
  logic [COLS-1:0]  shadow_reg [6];
  logic [COLS-1:0]  plane_reg  [6];
  logic [COL_W:0]   pc_sum;
  logic [COL_W-1:0] pc;
  logic [5:0]       pix;
  rgb3_t            upper, lower;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (row_req) state_next = BUILD;
      BUILD:   if (col_reg == COL_W'(COLS - 1)) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Scroll position runs independently of the builder, which works from a snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      offset_reg <= '0;
      div_reg    <= '0;
    end else if (frame_tick && !pause) begin
      if (div_reg == DIV_W'(SCROLL_DIV - 1)) begin
        div_reg    <= '0;
        offset_reg <= (offset_reg == COL_W'(COLS - 1)) ? '0 : offset_reg + 1'b1;
      end else begin
        div_reg <= div_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_reg          <= '0;
      snap_reg         <= '0;
      row_reg          <= '0;
      row_addr_out_reg <= '0;
      row_valid_reg    <= 1'b0;
      req_drop_reg     <= 1'b0;
    end else begin
      row_valid_reg <= 1'b0;
      req_drop_reg  <= row_req && (state_reg != IDLE);
      case (state_reg)
        IDLE: if (row_req) begin
          row_reg  <= row_addr;
          snap_reg <= offset_reg;
          col_reg  <= '0;
        end
        BUILD:  col_reg <= col_reg + 1'b1;
        COMMIT: begin
          row_valid_reg    <= 1'b1;
          row_addr_out_reg <= row_reg;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pc_sum = {1'b0, col_reg} + {1'b0, snap_reg};
    pc     = (pc_sum >= (COL_W + 1)'(COLS)) ? COL_W'(pc_sum - (COL_W + 1)'(COLS))
                                            : COL_W'(pc_sum);
  end

  band_color_lut #(
    .COLS   (COLS),
    .COL_W  (COL_W),
    .ROW_W  (ROW_W),
    .BAND_W (BAND_W),
    .DIAG   (DIAG)
  ) u_lut (
    .pc    (pc),
    .row   (row_reg),
    .upper (upper),
    .lower (lower)
  );

  assign pix = {upper.r, upper.g, upper.b, lower.r, lower.g, lower.b};

  // Plane gi holds pix[gi]: 5=r1, 4=g1, 3=b1, 2=r2, 1=g2, 0=b2.
  for (genvar gi = 0; gi < 6; gi++) begin : g_plane
    always_ff @(posedge clk) begin
      if (reset) begin
        shadow_reg[gi] <= '0;
        plane_reg[gi]  <= '0;
      end else if (state_reg == BUILD) begin
        shadow_reg[gi][col_reg] <= pix[gi];
      end else if (state_reg == COMMIT) begin
        plane_reg[gi] <= shadow_reg[gi];
      end
    end
  end

  assign r1           = plane_reg[5];
  assign g1           = plane_reg[4];
  assign b1           = plane_reg[3];
  assign r2           = plane_reg[2];
  assign g2           = plane_reg[1];
  assign b2           = plane_reg[0];
  assign row_ready    = (state_reg == IDLE);
  assign row_valid    = row_valid_reg;
  assign row_addr_out = row_addr_out_reg;
  assign req_drop     = req_drop_reg;

endmodule

// File: tb/tb_scroll_pattern_gen.sv
// Directed bench for scroll_pattern_gen: vertical-band and diagonal-band
// instances driven from one stimulus sequence, checked against hand values.
module tb_scroll_pattern_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        row_req = 1'b0;
  logic [4:0]  row_addr = '0;
  logic        frame_tick = 1'b0;
  logic        pause = 1'b0;

  logic        row_ready, row_valid, req_drop;
  logic [4:0]  row_addr_out;
  logic [31:0] r1, g1, b1, r2, g2, b2;

  logic        d_row_ready, d_row_valid, d_req_drop;
  logic [4:0]  d_row_addr_out;
  logic [31:0] d_r1, d_g1, d_b1, d_r2, d_g2, d_b2;

  int n_checks = 0;
  int n_errors = 0;
  int lat;
  int seen;

  // Expected plane sets packed {r1,g1,b1,r2,g2,b2}.
  localparam logic [191:0] P_ZERO = '0;
  localparam logic [191:0] P_OFF0 = {32'hC00003FF, 32'hFFF00000, 32'h000FFC00,
                                     32'hC00FFFFF, 32'hFFF003FF, 32'hFFFFFC00};
  localparam logic [191:0] P_OFF1 = {32'hE00001FF, 32'h7FF80000, 32'h0007FE00,
                                     32'hE007FFFF, 32'hFFF801FF, 32'h7FFFFE00};
  localparam logic [191:0] P_DIAG3 = {32'h000FFFFF, 32'hC00003FF, 32'h3FF00000,
                                      32'h3FFFFFFF, 32'hC00FFFFF, 32'hFFF003FF};

  always #5 clk = ~clk;

  scroll_pattern_gen #(.BAND_W(10), .SCROLL_DIV(2), .DIAG(0)) dut (
    .clk(clk), .reset(reset), .row_req(row_req), .row_addr(row_addr),
    .frame_tick(frame_tick), .pause(pause), .row_ready(row_ready),
    .row_valid(row_valid), .row_addr_out(row_addr_out),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2), .req_drop(req_drop)
  );

  scroll_pattern_gen #(.BAND_W(10), .SCROLL_DIV(2), .DIAG(1)) dut_d (
    .clk(clk), .reset(reset), .row_req(row_req), .row_addr(row_addr),
    .frame_tick(frame_tick), .pause(pause), .row_ready(d_row_ready),
    .row_valid(d_row_valid), .row_addr_out(d_row_addr_out),
    .r1(d_r1), .g1(d_g1), .b1(d_b1), .r2(d_r2), .g2(d_g2), .b2(d_b2),
    .req_drop(d_req_drop)
  );

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  // Issue a row request and count edges from the sampling edge to row_valid.
  task automatic request_row(input logic [4:0] addr, input logic with_tick, output int latency);
    row_addr   = addr;
    row_req    = 1'b1;
    frame_tick = with_tick;
    step();
    row_req    = 1'b0;
    frame_tick = 1'b0;
    latency    = 0;
    while (!row_valid && latency < 100) begin
      step();
      latency++;
    end
  endtask

  task automatic watch_quiet(input int n, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (row_valid || d_row_valid) hits++;
    end
  endtask

  function automatic logic [191:0] planes();
    return {r1, g1, b1, r2, g2, b2};
  endfunction

  function automatic logic [191:0] d_planes();
    return {d_r1, d_g1, d_b1, d_r2, d_g2, d_b2};
  endfunction

  initial begin
    // 1: reset state, then reset aborting a build in flight
    repeat (3) step();
    reset = 1'b0;
    check("reset_planes", planes(), P_ZERO);
    check("reset_flags", {189'd0, row_ready, row_valid, req_drop}, {189'd0, 3'b100});
    check("reset_row_out", 192'(row_addr_out), 192'd0);
    $display("step 1a: reset state observed");

    row_addr = 5'd5;
    row_req  = 1'b1;
    step();
    row_req = 1'b0;
    repeat (10) step();
    check("build_not_ready", 192'(row_ready), 192'd0);
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check("abort_planes", planes(), P_ZERO);
    check("abort_ready", 192'(row_ready), 192'd1);
    watch_quiet(40, seen);
    check("abort_no_valid", 192'(seen), 192'd0);
    $display("step 1b: reset mid-build, row_valid pulses seen=%0d", seen);

    // 2: offset 0, row 0, latency and planes
    request_row(5'd0, 1'b0, lat);
    check("lat_row0", 192'(lat), 192'd33);
    check("planes_off0", planes(), P_OFF0);
    check("row_out0", 192'(row_addr_out), 192'd0);
    step();
    check("valid_pulse", 192'(row_valid), 192'd0);
    $display("step 2: row 0 latency=%0d r1=%h r2=%h", lat, r1, r2);

    // 3: two ticks = one scroll step, then 62 more wrap back to offset 0
    ticks(2);
    request_row(5'd0, 1'b0, lat);
    check("planes_off1", planes(), P_OFF1);
    $display("step 3a: offset 1 r1=%h", r1);
    ticks(62);
    request_row(5'd0, 1'b0, lat);
    check("planes_wrap", planes(), P_OFF0);
    $display("step 3b: after 64 ticks r1=%h", r1);

    // 4: dropped request at col 5 plus ticks mid-build
    row_addr = 5'd7;
    row_req  = 1'b1;
    step();
    row_req = 1'b0;
    lat = 0;
    repeat (5) begin step(); lat++; end
    row_addr = 5'd9;
    row_req  = 1'b1;
    step();
    lat++;
    row_req = 1'b0;
    check("req_drop_pulse", 192'(req_drop), 192'd1);
    check("ready_in_build", 192'(row_ready), 192'd0);
    step();
    lat++;
    check("req_drop_clear", 192'(req_drop), 192'd0);
    ticks(2);
    lat += 4;
    while (!row_valid && lat < 100) begin step(); lat++; end
    check("lat_row7", 192'(lat), 192'd33);
    check("row_out7", 192'(row_addr_out), 192'd7);
    check("snapshot_kept", planes(), P_OFF0);
    watch_quiet(40, seen);
    check("dropped_no_build", 192'(seen), 192'd0);
    $display("step 4: row 7 latency=%0d, extra row_valid=%0d", lat, seen);
    request_row(5'd0, 1'b0, lat);
    check("tick_in_build_applied", planes(), P_OFF1);
    ticks(62);

    // Simultaneous request and scroll step: build uses pre-update offset
    ticks(1);
    request_row(5'd0, 1'b1, lat);
    check("simul_snapshot", planes(), P_OFF0);
    request_row(5'd0, 1'b0, lat);
    check("simul_step_applied", planes(), P_OFF1);
    $display("step 4b: simultaneous req/tick r1=%h", r1);
    ticks(62);

    // 5: paused ticks do not scroll
    pause = 1'b1;
    ticks(10);
    pause = 1'b0;
    request_row(5'd0, 1'b0, lat);
    check("pause_frozen", planes(), P_OFF0);
    $display("step 5: paused r1=%h", r1);

    // 6: diagonal bands on row 3 from a fresh reset
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    request_row(5'd3, 1'b0, lat);
    check("diag_planes", d_planes(), P_DIAG3);
    check("diag_row_out", 192'(d_row_addr_out), 192'd3);
    check("vert_row3", planes(), P_OFF0);
    $display("step 6: diag row 3 r1=%h g1=%h b1=%h", d_r1, d_g1, d_b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
